// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared state encoding for the restoring divider
package seq_restoring_divider_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_restoring_divider_div_cell.sv
// div_cell: one-bit full subtractor slice of the trial-subtract chain
module div_cell (
  input  logic r_in,
  input  logic d_in,
  input  logic b_in,
  output logic diff,
  output logic b_out
);
  assign diff  = r_in ^ d_in ^ b_in;
  assign b_out = (~r_in & d_in) | (~(r_in ^ d_in) & b_in);
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: N-bit unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q, d;
  logic [N:0]    r, r_sh, t, d_ext;
  logic [N+1:0]  b;
  assign r_sh  = {r[N-1:0], q[N-1]};
  assign d_ext = {1'b0, d};
  assign b[0]  = 1'b0;
  for (genvar i = 0; i <= N; i++) begin : g_sub
    div_cell u_cell (
      .r_in (r_sh[i]),
      .d_in (d_ext[i]),
      .b_in (b[i]),
      .diff (t[i]),
      .b_out(b[i+1])
    );
  end
  assign busy = state != S_IDLE;
  // control FSM, iteration registers and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          d           <= divisor;
          cnt         <= CW'(N);
          div_by_zero <= 1'b0;
          q           <= divisor == '0 ? '1 : dividend;
          r           <= divisor == '0 ? {1'b0, dividend} : '0;
          state       <= divisor == '0 ? S_DONE : S_RUN;
        end
        S_RUN: begin
          r     <= b[N+1] ? r_sh : t;
          q     <= {q[N-2:0], ~b[N+1]};
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? S_DONE : S_RUN;
        end
        S_DONE: begin
          done        <= 1'b1;
          quotient    <= q;
          remainder   <= r[N-1:0];
          div_by_zero <= d == '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the restoring divider
module tb_seq_restoring_divider;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;
  int           n_assert = 0;
  int           n_fail = 0;
  int           lat, bcnt;
  logic [N-1:0] a, b, hq, hr;
  seq_restoring_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // called at a negedge; returns negedges from the cycle after acceptance to done
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, output int l);
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 0;
    while (!done && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(100, 7, lat);
    chk("t1_lat", lat, 9);
    chk("t1_q", quotient, 14);
    chk("t1_r", remainder, 2);
    chk("t1_dz", div_by_zero, 0);
    run_op(255, 1, lat);
    chk("t2a_lat", lat, 9);
    chk("t2a_q", quotient, 255);
    chk("t2a_r", remainder, 0);
    run_op(5, 9, lat);
    chk("t2b_spacing_lat", lat, 9);
    chk("t2b_q", quotient, 0);
    chk("t2b_r", remainder, 5);
    @(negedge clk);
    run_op(200, 0, lat);
    chk("t3_lat", lat, 1);
    chk("t3_q", quotient, 8'hFF);
    chk("t3_r", remainder, 200);
    chk("t3_dz", div_by_zero, 1);
    @(negedge clk);
    dividend = 100;
    divisor  = 7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt  = 0;
    while (busy && bcnt < 40) begin
      bcnt++;
      if (bcnt == 3) begin
        dividend = 50;
        divisor  = 5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_busy_cycles", bcnt, 9);
    chk("t4_done", done, 1);
    chk("t4_q", quotient, 14);
    chk("t4_r", remainder, 2);
    chk("t4_dz_cleared", div_by_zero, 0);
    @(negedge clk);
    chk("t4_no_requeue", busy, 0);
    dividend = 200;
    divisor  = 3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_q", quotient, 0);
    chk("t5_rst_r", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle", busy, 0);
    run_op(200, 3, lat);
    chk("t5_lat", lat, 9);
    chk("t5_q", quotient, 66);
    chk("t5_r", remainder, 2);
    for (int i = 0; i < 300; i++) begin
      a = N'($urandom);
      b = N'($urandom_range(1, 255));
      run_op(a, b, lat);
      chk("rnd_lat", lat, 9);
      chk("rnd_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk("rnd_r_lt_d", remainder < b, 1);
      hq = quotient;
      hr = remainder;
      dividend = ~a;
      divisor  = ~b;
      @(negedge clk);
      chk("rnd_done_width", done, 0);
      chk("rnd_hold_q", quotient, 32'(hq));
      chk("rnd_hold_r", remainder, 32'(hr));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
